// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
//
// Purpose:
//   Computes the single-cycle logic results (AND/OR) and drives the ex-stage
//   bypass (wd/wreg/wdata) back to decode in the same cycle. When the EX_DIV_EN
//   macro is defined, it also runs a multi-cycle radix-2 restoring divider for
//   DIV/DIVU and holds the front of the pipeline with stallreq_o while busy.
//   If EX_DIV_EN is undefined, DIV/DIVU behave as NOP and the divider outputs
//   are tied low.
//
// Ports:
//   clk, rst     pipeline clock, synchronous active-high reset
//   flush        synchronous flush, aborts any divide in flight
//   aluop_i      operation code from id_ex
//   alusel_i     result class select
//   reg1_i       operand 1 (dividend for DIV/DIVU)
//   reg2_i       operand 2 (divisor for DIV/DIVU)
//   wd_i, wreg_i destination address / write enable
//   wd_o, wreg_o, wdata_o  to ex_mem and decode bypass
//   whilo_o      HI/LO write enable (only in the divider's result cycle)
//   hi_o, lo_o   remainder, quotient
//   stallreq_o   request to hold pc/if_id/id_ex

module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] EXE_AND_OP    = 8'h24;
    localparam logic [7:0] EXE_OR_OP     = 8'h25;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;

    // ------------------------------------------------------------------
    // Logic path and bypass
    // ------------------------------------------------------------------
    logic [31:0] logic_res;

    always_comb begin
        logic_res = 32'd0;
        unique case (aluop_i)
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            default:    logic_res = 32'd0;
        endcase
    end

    always_comb begin
        wd_o    = 5'd0;
        wreg_o  = 1'b0;
        wdata_o = 32'd0;
        if (!rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
            if (alusel_i == EXE_RES_LOGIC) begin
                wdata_o = logic_res;
            end
        end
    end

`ifdef EX_DIV_EN
    // ------------------------------------------------------------------
    // Iterative divider
    // ------------------------------------------------------------------
    localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP = 8'h1B;
    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} div_state_e;

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // quo_q starts as the dividend magnitude; its MSB shifts into the partial
    // remainder each step while quotient bits shift in at the LSB.
    logic [31:0]     quo_q, quo_d;
    logic [31:0]     rem_q, rem_d;
    logic [31:0]     divisor_q, divisor_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic        is_div;
    logic        is_signed;
    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] shifted;
    logic [33:0] trial;

    assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign is_signed = (aluop_i == EXE_DIV_OP);
    assign op1_abs   = (is_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign op2_abs   = (is_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

    // Trial subtraction; trial[33] set means the divisor did not fit.
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = {1'b0, shifted} - {2'b00, divisor_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            DivFree: begin
                if (is_div) begin
                    cnt_d = '0;
                    if (reg2_i == 32'd0) begin
                        state_d   = DivByZero;
                        quo_d     = 32'd0;
                        rem_d     = 32'd0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = DivOn;
                        quo_d     = op1_abs;
                        rem_d     = 32'd0;
                        divisor_d = op2_abs;
                        neg_quo_d = is_signed && (reg1_i[31] ^ reg2_i[31]);
                        neg_rem_d = is_signed && reg1_i[31];
                    end
                end
            end
            DivByZero: state_d = DivEnd;
            DivOn: begin
                if (trial[33]) begin
                    rem_d = shifted[31:0];
                end else begin
                    rem_d = trial[31:0];
                end
                quo_d = {quo_q[30:0], ~trial[33]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                    state_d = DivEnd;
                end
            end
            DivEnd:  state_d = DivFree;
            default: state_d = DivFree;
        endcase

        // Flush overrides every transition, including a new issue.
        if (flush) begin
            state_d = DivFree;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        whilo_o    = 1'b0;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        stallreq_o = 1'b0;
        if (!rst) begin
            stallreq_o = is_div && (state_q != DivEnd);
            if (state_q == DivEnd) begin
                whilo_o = 1'b1;
                lo_o    = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
                hi_o    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
            end
        end
    end
`else
    // Divider disabled: clk and flush have no consumers.
    logic unused_div;
    assign unused_div = clk ^ flush;

    assign whilo_o    = 1'b0;
    assign hi_o       = 32'd0;
    assign lo_o       = 32'd0;
    assign stallreq_o = 1'b0;
`endif

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits between the id_ex pipeline register and the ex_mem register.
- Consumes the decoded aluop/alusel/operands/destination that decode produces.
- Computes single-cycle logic results and runs a multi-cycle iterative DIV/DIVU, stalling the pipeline while busy.
- Drives the ex-stage bypass (wreg/wd/wdata) back to decode.

Parameters:
- DIV_CYCLES, 32, iteration count of the radix-2 restoring divider; must equal the operand width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset (`Enable = 1)
- flush  input  1  synchronous pipeline flush; aborts any divide in flight
- aluop_i  input  8  `AluOpBus, operation code from id_ex
- alusel_i  input  3  `AluSelBus, result class select
- reg1_i  input  32  operand 1 (rs or immediate)
- reg2_i  input  32  operand 2 (rt or immediate)
- wd_i  input  5  destination register address
- wreg_i  input  1  destination write enable
- wd_o  output  5  to ex_mem and to decode bypass
- wreg_o  output  1  to ex_mem and to decode bypass
- wdata_o  output  32  to ex_mem and to decode bypass
- whilo_o  output  1  HI/LO write enable
- hi_o  output  32  remainder
- lo_o  output  32  quotient
- stallreq_o  output  1  request to hold pc/if_id/id_ex

Behaviour:
- Opcodes:
  - EXE_NOP_OP = 8'h00
  - EXE_AND_OP = 8'h24
  - EXE_OR_OP = 8'h25
  - EXE_DIV_OP = 8'h1A
  - EXE_DIVU_OP = 8'h1B
  - EXE_RES_NOP = 3'b000
  - EXE_RES_LOGIC = 3'b001
- Logic path (combinational, 0-cycle):
  - AND → reg1_i & reg2_i; OR → reg1_i | reg2_i; any other aluop → 0.
  - wdata_o = logic result when alusel_i = EXE_RES_LOGIC, else 0.
  - wd_o = wd_i; wreg_o = wreg_i.
  - Bypass values are valid in the same cycle the instruction is in EX.
- Reset (rst = 1 at clk edge): divider state → DivFree, iteration counter → 0, dividend/divisor regs → 0. While rst = 1, all outputs are 0, including stallreq_o.
- Divider FSM, states DivFree, DivByZero, DivOn, DivEnd:
  - DivFree + aluop ∈ {DIV, DIVU} + !flush:
    - divisor == 0 → DivByZero.
    - Otherwise → DivOn. Latch |reg1|, |reg2| (signed op) or raw values (DIVU), latch the sign flags, counter = 0.
  - DivByZero: one cycle. Result quotient = 0, remainder = 0. → DivEnd.
  - DivOn: one restoring step per cycle (shift left, trial-subtract the 33-bit partial remainder, set the quotient bit). Counter++. After DIV_CYCLES steps → DivEnd.
  - DivEnd: result valid. Signed fixup:
    - quotient negated when the operand signs differ;
    - remainder takes the sign of the dividend.
    - Then → DivFree unconditionally.
- stallreq_o:
  - = 1 combinationally whenever aluop_i is DIV/DIVU and the state is not DivEnd. This includes the issue cycle in DivFree.
  - = 0 in DivEnd, so id_ex advances on that edge.
- Latency:
  - Nonzero divisor: issue + 32 + 1 = 34 cycles in EX.
  - Divide by zero: 3 cycles.
- whilo_o = 1 only in DivEnd; hi_o/lo_o = result. Otherwise whilo_o = 0 and hi_o = lo_o = 0.
- The DIV instruction carries wreg_i = 0 from decode; ex_stage passes it through unchanged.
- flush = 1 at an edge: state → DivFree, counter → 0, no whilo pulse. flush has priority over all transitions; rst has priority over flush.
- Operands latched at DivFree exit. Changes to reg1_i/reg2_i during DivOn are ignored.
- 0x80000000 / -1 (signed): no trap; quotient = 0x80000000, remainder = 0.

Optional Feature:
- Macro EX_DIV_EN.
- Defined: divider FSM as above.
- Undefined:
  - no divider logic;
  - DIV/DIVU behave as NOP: wdata_o = 0, whilo_o = 0;
  - stallreq_o tied 0; hi_o/lo_o tied 0.

Test Plan:
1. AND reg1 = 0xF0F0_1234, reg2 = 0x0FF0_FFFF, wd = 5, wreg = 1 → same cycle wdata_o = 0x00F0_1234, wd_o = 5, wreg_o = 1, stallreq_o = 0.
2. DIVU 100/7 held stable → stallreq_o high 33 cycles, then one DivEnd cycle with whilo_o = 1, lo_o = 14, hi_o = 2, stallreq_o = 0; next cycle back in DivFree.
3. DIV -7/2 (0xFFFF_FFF9 / 2) → DivEnd: lo_o = 0xFFFF_FFFD (-3), hi_o = 0xFFFF_FFFF (-1).
4. DIV 5/0 → stallreq_o high 2 cycles, DivEnd on 3rd cycle with whilo_o = 1, lo_o = 0, hi_o = 0.
5. DIVU 1000/3, flush = 1 at iteration 10 → next cycle state DivFree, whilo_o never asserts. New DIVU 9/3 then completes in 34 cycles with lo_o = 3, hi_o = 0.
6. rst asserted mid-DivOn for 1 cycle → all outputs 0 during reset. After release, state DivFree; if the DIV is still presented, it restarts with the full 34-cycle latency.
